// File: rtl/vga_framebuffer.sv
// 320x240x3 frame buffer with a single-pixel plot port, bulk clear, and
// 640x480@60 VGA scan-out that doubles each stored pixel in both axes.
module vga_framebuffer #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [8:0] vga_x,
  input  logic [7:0] vga_y,
  input  logic [2:0] vga_colour,
  input  logic       vga_plot,
  input  logic       clear,
  output logic       busy,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n
);

  localparam int unsigned NPIX  = 76800;
  localparam int          DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0] H_VIS    = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd752;
  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] V_SYNC_S = 10'd490;
  localparam logic [9:0] V_SYNC_E = 10'd492;
  localparam logic [9:0] V_LAST   = 10'd524;

  localparam logic [16:0] CLR_LAST = 17'd76799;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [DIV_W-1:0] div_cnt;
  logic             pix_en;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             visible;
  logic             hs_raw;
  logic             vs_raw;
  logic [8:0]       row;
  logic [8:0]       col;
  logic [16:0]      rd_addr;
  logic [2:0]       rd_data;

  logic [0:0]       state;
  logic [16:0]      clr_cnt;
  logic             plot_ok;
  logic [16:0]      plot_addr;
  logic             we;
  logic [16:0]      wr_addr;
  logic [2:0]       wr_data;

  logic             vis_d;
  logic             hs_d;
  logic             vs_d;

  logic [2:0]       mem [0:NPIX-1];

  assign pix_en = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt <= '0;
    end else if (pix_en) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  assign visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_raw  = !((h_cnt >= H_SYNC_S) && (h_cnt < H_SYNC_E));
  assign vs_raw  = !((v_cnt >= V_SYNC_S) && (v_cnt < V_SYNC_E));

  // row*320 = (row<<8)+(row<<6); address held at 0 in blanking to stay in range
  assign row     = v_cnt[9:1];
  assign col     = h_cnt[9:1];
  assign rd_addr = visible ? ({row, 8'b0} + {2'b0, row, 6'b0} + {8'b0, col}) : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      clr_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (clear) begin
        state   <= S_CLEAR;
        clr_cnt <= '0;
      end
    end else begin
      if (clr_cnt == CLR_LAST) begin
        state <= S_IDLE;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  assign busy = (state == S_CLEAR);

  assign plot_ok   = (state == S_IDLE) && vga_plot && (vga_x < 9'd320) && (vga_y < 8'd240);
  assign plot_addr = {1'b0, vga_y, 8'b0} + {3'b0, vga_y, 6'b0} + {8'b0, vga_x};
  assign we        = plot_ok || busy;
  assign wr_addr   = busy ? clr_cnt : plot_addr;
  assign wr_data   = busy ? 3'b000 : vga_colour;

  // Read and write share one edge, so a colliding read returns the old data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vis_d       <= 1'b0;
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else begin
      vis_d       <= visible;
      hs_d        <= hs_raw;
      vs_d        <= vs_raw;
      vga_r       <= {8{vis_d & rd_data[2]}};
      vga_g       <= {8{vis_d & rd_data[1]}};
      vga_b       <= {8{vis_d & rd_data[0]}};
      vga_hs      <= hs_d;
      vga_vs      <= vs_d;
      vga_blank_n <= vis_d;
    end
  end

  assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_framebuffer.sv
// Bench for vga_framebuffer: a time-indexed screen/RAM model predicts every
// output each cycle; directed plot, bound, clear and reset-abort scenarios.
module tb_vga_framebuffer;

  localparam int CLK_DIV = 2;
  localparam int NPIX    = 76800;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [8:0] vga_x = '0;
  logic [7:0] vga_y = '0;
  logic [2:0] vga_colour = '0;
  logic       vga_plot = 1'b0;
  logic       clear = 1'b0;
  logic       busy;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_framebuffer #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rstn(rstn), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .clear(clear),
    .busy(busy), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n)
  );

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      if (errors >= 50) finish_run();
    end
  endtask

  function automatic logic [23:0] expand(input logic [2:0] c);
    return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  // Reference: RAM image plus screen position derived from edges since release.
  bit [2:0]    ref_mem [NPIX];
  bit          known   [NPIX];
  longint      edges = 0;
  int          clear_left = 0;
  int          m_p, m_h, m_v, m_a;
  bit          s1_vis = 1'b0, s1_hs = 1'b1, s1_vs = 1'b1, s1_known = 1'b1;
  bit [2:0]    s1_col = '0;
  logic [23:0] exp_rgb = '0;
  bit          exp_hs = 1'b1, exp_vs = 1'b1, exp_blank = 1'b0, exp_known = 1'b1;
  bit          scan_chk = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      edges = 0; clear_left = 0;
      s1_vis = 1'b0; s1_hs = 1'b1; s1_vs = 1'b1; s1_known = 1'b1;
      exp_rgb = '0; exp_hs = 1'b1; exp_vs = 1'b1; exp_blank = 1'b0; exp_known = 1'b1;
    end else begin
      exp_blank = s1_vis;
      exp_hs    = s1_hs;
      exp_vs    = s1_vs;
      exp_known = !s1_vis || s1_known;
      exp_rgb   = s1_vis ? expand(s1_col) : 24'h0;
      m_p = int'(edges / CLK_DIV);
      m_h = m_p % 800;
      m_v = (m_p / 800) % 525;
      s1_vis = (m_h < 640) && (m_v < 480);
      s1_hs  = !((m_h >= 656) && (m_h < 752));
      s1_vs  = !((m_v >= 490) && (m_v < 492));
      if (s1_vis) begin
        m_a = (m_v / 2) * 320 + m_h / 2;
        s1_col   = ref_mem[m_a];
        s1_known = known[m_a];
      end
      if (clear_left > 0) begin
        ref_mem[NPIX - clear_left] = 3'b000;
        known[NPIX - clear_left]   = 1'b1;
        clear_left--;
      end else begin
        if (vga_plot && vga_x < 320 && vga_y < 240) begin
          ref_mem[int'(vga_y) * 320 + int'(vga_x)] = vga_colour;
          known[int'(vga_y) * 320 + int'(vga_x)]   = 1'b1;
        end
        if (clear) clear_left = NPIX;
      end
      edges++;
    end
  end

  always @(negedge clk) begin
    if (scan_chk) begin
      check_val("sync", {vga_hs, vga_vs, vga_blank_n, vga_sync_n, busy},
                {exp_hs, exp_vs, exp_blank, 1'b0, clear_left > 0});
      if (exp_known) check_val("rgb", {vga_r, vga_g, vga_b}, exp_rgb);
    end
  end

  task automatic do_plot(input int px, input int py, input logic [2:0] c);
    @(negedge clk);
    vga_x = px[8:0]; vga_y = py[7:0]; vga_colour = c; vga_plot = 1'b1;
    @(negedge clk);
    vga_plot = 1'b0;
  endtask

  int          ph [12] = '{10, 11, 12, 9, 10, 10, 0, 639, 0, 78, 80, 79};
  int          pv [12] = '{6, 7, 6, 6, 4, 8, 1, 0, 2, 6, 6, 7};
  logic [23:0] pe [12] = '{24'hFF00FF, 24'hFF00FF, 24'h0, 24'h0, 24'h0, 24'h0,
                           24'hFFFF00, 24'h00FFFF, 24'h0, 24'h0, 24'hFFFF00, 24'h0};

  initial begin
    #1_500_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, cnt, nf, blank_hi, hs_lo, p, sel;
    int falls [2];
    logic prev_hs;

    scan_chk = 1'b1;
    repeat (4) @(negedge clk);
    check_val("rst_rgb", {vga_r, vga_g, vga_b}, 24'h0);
    check_val("rst_sync", {vga_hs, vga_vs, vga_blank_n, vga_sync_n}, 4'b1100);
    check_val("rst_busy", busy, 0);
    #2 rstn = 1'b1;

    // Full clear, with a plot dropped halfway through.
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 80000; i++) begin
      if (busy) busy_cnt++;
      else if (busy_cnt > 0) break;
      if (busy_cnt == 40000) begin
        vga_x = 9'd7; vga_y = 8'd20; vga_colour = 3'b111; vga_plot = 1'b1;
      end else begin
        vga_plot = 1'b0;
      end
      @(negedge clk);
    end
    vga_plot = 1'b0;
    check_val("clear_len", busy_cnt, 76800);

    // Partial clear aborted by reset after addresses 0..999 are cleared.
    do_plot(39, 3, 3'b111);
    @(negedge clk);
    vga_x = 9'd40; vga_y = 8'd3; vga_colour = 3'b110; vga_plot = 1'b1; clear = 1'b1;
    @(negedge clk);
    vga_plot = 1'b0; clear = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3000 && cnt < 1001; i++) begin
      if (busy) cnt++;
      if (cnt < 1001) @(negedge clk);
    end
    check_val("abort_reach", cnt, 1001);
    #2 rstn = 1'b0;
    #1;
    check_val("abort_busy", busy, 0);
    check_val("abort_out", {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n},
              {24'h0, 3'b110});
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;

    falls[0] = -1; falls[1] = -1; nf = 0; blank_hi = 0; hs_lo = 0; prev_hs = 1'b1;
    fork
      begin
        do_plot(5, 3, 3'b101);
        do_plot(0, 0, 3'b110);
        do_plot(319, 0, 3'b011);
        do_plot(320, 0, 3'b111);
        do_plot(0, 240, 3'b111);
        do_plot(319, 239, 3'b100);
        for (int k = 0; k < 24; k++) begin
          sel = int'($urandom_range(0, 3));
          if (sel < 2)
            do_plot(int'($urandom_range(1, 319)), 1, 3'($urandom));
          else if (sel == 2)
            do_plot(int'($urandom_range(320, 511)), int'($urandom_range(0, 3)), 3'($urandom));
          else
            do_plot(int'($urandom_range(0, 319)), int'($urandom_range(240, 255)), 3'($urandom));
        end
      end
      begin
        for (int n = 1; n <= 12000; n++) begin
          @(negedge clk);
          if (prev_hs && !vga_hs && nf < 2) begin
            falls[nf] = n;
            nf++;
          end
          prev_hs = vga_hs;
          if (n <= 1600 && vga_blank_n) blank_hi++;
          if (n <= 2000 && !vga_hs) hs_lo++;
          if (n >= 2 && (n - 2) % CLK_DIV == 0) begin
            p = (n - 2) / CLK_DIV;
            for (int k = 0; k < 12; k++)
              if (p == pv[k] * 800 + ph[k])
                check_val($sformatf("pix_h%0d_v%0d", ph[k], pv[k]),
                          {vga_r, vga_g, vga_b}, pe[k]);
          end
        end
      end
    join

    check_val("hs_first_fall", falls[0], 2 + 656 * CLK_DIV);
    check_val("hs_period", falls[1] - falls[0], 800 * CLK_DIV);
    check_val("hs_low", hs_lo, 96 * CLK_DIV);
    check_val("blank_line", blank_hi, 640 * CLK_DIV);
    finish_run();
  end

endmodule
